phase_seq_ctrl: RTL and testbench
=================================

Name: phase_seq_ctrl

Overview:
- Run-phase sequencer for a DUT sharing the CLK domain.
- Holds the DUT in reset for a fixed time, then walks it through CONFIG, MAIN and SHUTDOWN phases, mirroring the run-time phase order our sequences use.
- Each phase advances on a done handshake from the stimulus side. Per-phase timeout and abort handling are included.
- Sits between the testbench/top-level control and the DUT reset and phase-status signals.

Parameters:
- RST_CYCLES, 8, number of cycles dut_rst is held asserted in the RESET phase (>=1).
- TIMEOUT, 1024, maximum cycles spent in CONFIG, MAIN or SHUTDOWN before error (>=2).
- CW, $clog2(TIMEOUT+RST_CYCLES+1), internal counter width (derived, not overridden).

Ports:
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  asynchronous active-high reset
- start  input  1  launch/relaunch a phase sequence
- abort  input  1  request early shutdown
- cfg_done  input  1  CONFIG phase complete
- main_done  input  1  MAIN phase complete
- shut_done  input  1  SHUTDOWN phase complete
- dut_rst  output  1  reset driven to the DUT, active-high
- phase  output  3  current phase code
- phase_pulse  output  1  one-cycle strobe on every phase entry
- busy  output  1  sequence in progress
- done  output  1  sequence completed normally
- timeout_err  output  1  sticky timeout flag

Behaviour:
- The clock and reset are one CLK and one RST. RST is asynchronous and active-high. All outputs are registered.
- Reset values: phase=0 (IDLE), dut_rst=1, phase_pulse=0, busy=0, done=0, timeout_err=0, counter=0.
- Phase codes: IDLE=0, RESET=1, CONFIG=2, MAIN=3, SHUTDOWN=4, DONE=5, ERROR=7. Code 6 is unused; if it is ever reached, the next state is IDLE.
- Latency: an input sampled at edge k takes effect on the outputs after edge k. There is one cycle of latency and no combinational input-to-output path.
- Counter: cleared to 0 on every phase entry and incremented each cycle while in the phase. It saturates and never wraps.
- phase_pulse is 1 in the first cycle of every new phase, including IDLE after an abort. It is never asserted by RST.
- Transitions:
  - IDLE: start=1 -> RESET. Other inputs are ignored.
  - RESET: dut_rst=1. After exactly RST_CYCLES cycles in RESET -> CONFIG. abort=1 -> IDLE, with dut_rst remaining 1.
  - CONFIG: dut_rst=0 from the first CONFIG cycle.
    - abort -> SHUTDOWN, with priority over cfg_done.
    - else cfg_done -> MAIN.
    - else if counter==TIMEOUT-1 -> ERROR.
  - MAIN:
    - main_done or abort -> SHUTDOWN. If both are asserted together, the result is SHUTDOWN.
    - else if counter==TIMEOUT-1 -> ERROR.
  - SHUTDOWN: abort is ignored.
    - shut_done -> DONE.
    - else if counter==TIMEOUT-1 -> ERROR.
  - DONE: done=1, dut_rst=0. start -> RESET, clearing done.
  - ERROR: timeout_err=1 and dut_rst=1. start -> RESET, clearing timeout_err. No other exit.
- Done vs timeout: a done input in the cycle with counter==TIMEOUT-1 wins. Each phase therefore allows up to TIMEOUT cycles.
- Done inputs outside their own phase are ignored.
- busy=1 exactly in RESET, CONFIG, MAIN and SHUTDOWN.
- dut_rst=1 in IDLE, RESET and ERROR.
- start while busy is ignored.
- RST asserted mid-sequence forces all reset values immediately, without waiting for a clock edge.

Test Plan:
Bench parameters are RST_CYCLES=4 and TIMEOUT=16.
1. Nominal run: start pulse; cfg_done 3 cycles after CONFIG entry; main_done after 5 cycles; shut_done after 2 cycles. Required response:
   - phase goes 1 -> 2 -> 3 -> 4 -> 5.
   - dut_rst is high for exactly 4 RESET cycles.
   - phase_pulse is asserted 5 times.
   - done=1 and busy=0 at the end.
2. Timeout: enter MAIN and never assert main_done. Required response: phase=7 exactly 16 cycles after MAIN entry, with timeout_err=1 and dut_rst=1. A later start gives phase=1 and timeout_err=0.
3. Boundary: assert cfg_done in the 16th CONFIG cycle (counter=15). Required response: phase=3, no error. Asserting cfg_done one cycle later instead gives phase=7.
4. Abort: abort together with cfg_done in CONFIG -> phase=4 next cycle. Abort during RESET cycle 2 -> phase=0 with dut_rst=1. Abort in SHUTDOWN -> no change.
5. Async reset: assert RST mid-MAIN between clock edges. Required response: phase=0, dut_rst=1 and busy=0 before the next edge. The bench also checks that start during busy has no effect.

Source files
------------

// File: rtl/phase_seq_ctrl_if.sv
// Control/status bundle between the run-phase sequencer and its controller.
// The master side drives the launch/abort/done handshakes; the slave side
// (the sequencer) returns the DUT reset and phase status.
interface phase_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic       cfg_done;
    logic       main_done;
    logic       shut_done;
    logic       dut_rst;
    logic [2:0] phase;
    logic       phase_pulse;
    logic       busy;
    logic       done;
    logic       timeout_err;

    modport master (
        output start, abort, cfg_done, main_done, shut_done,
        input  dut_rst, phase, phase_pulse, busy, done, timeout_err
    );

    modport slave (
        input  start, abort, cfg_done, main_done, shut_done,
        output dut_rst, phase, phase_pulse, busy, done, timeout_err
    );
endinterface

// File: rtl/phase_seq_ctrl.sv
// Run-phase sequencer: holds the DUT in reset for RST_CYCLES, then walks it
// through CONFIG -> MAIN -> SHUTDOWN, each advanced by a done handshake and
// guarded by a TIMEOUT-cycle watchdog. Every output is a flop loaded from
// the next-state decode, so there is no combinational input-to-output path.
module phase_seq_ctrl #(
    parameter int RST_CYCLES = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    phase_seq_ctrl_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT + RST_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [CW-1:0] CNT_RST_END = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TO_END  = CW'(TIMEOUT - 1);

    // Encodings double as the externally visible phase code; 6 is unused.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESET    = 3'd1,
        S_CONFIG   = 3'd2,
        S_MAIN     = 3'd3,
        S_SHUTDOWN = 3'd4,
        S_DONE     = 3'd5,
        S_ERROR    = 3'd7
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_dut_rst;
    logic           r_pulse;
    logic           r_busy;
    logic           r_done;
    logic           r_terr;

    logic           w_rst_end;
    logic           w_to_end;
    logic           w_dut_rst;
    logic           w_busy;
    logic           w_done;
    logic           w_terr;

    assign w_rst_end = (r_cnt == CNT_RST_END);
    assign w_to_end  = (r_cnt == CNT_TO_END);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode. Done handshakes are checked ahead of the timeout,
    // so a done arriving on the last allowed cycle still advances normally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RESET;
            end
            S_RESET: begin
                if (bus.abort)     w_next = S_IDLE;
                else if (w_rst_end) w_next = S_CONFIG;
            end
            S_CONFIG: begin
                if (bus.abort)         w_next = S_SHUTDOWN;
                else if (bus.cfg_done) w_next = S_MAIN;
                else if (w_to_end)     w_next = S_ERROR;
            end
            S_MAIN: begin
                if (bus.main_done || bus.abort) w_next = S_SHUTDOWN;
                else if (w_to_end)              w_next = S_ERROR;
            end
            S_SHUTDOWN: begin
                // abort is deliberately ignored: shutdown is already underway
                if (bus.shut_done)  w_next = S_DONE;
                else if (w_to_end)  w_next = S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (bus.start) w_next = S_RESET;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Status decode of the state about to be entered, so the flops below
    // present it in the same cycle the phase code changes.
    always_comb begin
        w_dut_rst = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_terr    = 1'b0;
        case (w_next)
            S_IDLE, S_RESET:                     w_dut_rst = 1'b1;
            default:                             w_dut_rst = 1'b0;
        endcase
        case (w_next)
            S_RESET, S_CONFIG, S_MAIN, S_SHUTDOWN: w_busy = 1'b1;
            S_DONE:                                w_done = 1'b1;
            S_ERROR: begin
                w_terr    = 1'b1;
                w_dut_rst = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered status outputs and the phase-entry strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dut_rst <= 1'b1;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_dut_rst <= w_dut_rst;
            r_pulse   <= (w_next != r_state);
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_terr    <= w_terr;
        end
    end

    // Cycles-in-phase counter: cleared on entry, saturating otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                    r_cnt <= '0;
        else if (w_next != r_state) r_cnt <= '0;
        else if (r_cnt != CNT_MAX)  r_cnt <= r_cnt + CW'(1);
    end

    assign bus.phase       = r_state;
    assign bus.dut_rst     = r_dut_rst;
    assign bus.phase_pulse = r_pulse;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_terr;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Bench for phase_seq_ctrl with RST_CYCLES=4, TIMEOUT=16. Each cycle's
// expected status is queued as stimulus is applied; the sampled status is
// queued after the edge, and each test drains and compares both queues.
module tb_phase_seq_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    phase_seq_ctrl_if u_if();

    phase_seq_ctrl #(.RST_CYCLES(4), .TIMEOUT(16)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if.slave)
    );

    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    int n_pass  = 0;
    int n_total = 0;

    // Expected status word {phase, dut_rst, busy, done, timeout_err, pulse}.
    function automatic logic [7:0] mk(input logic [2:0] ph, input logic pl);
        logic r_e, b_e, d_e, t_e;
        r_e = (ph == 3'd0) || (ph == 3'd1) || (ph == 3'd7);
        b_e = (ph >= 3'd1) && (ph <= 3'd4);
        d_e = (ph == 3'd5);
        t_e = (ph == 3'd7);
        return {ph, r_e, b_e, d_e, t_e, pl};
    endfunction

    function automatic logic [7:0] sample();
        return {u_if.phase, u_if.dut_rst, u_if.busy, u_if.done,
                u_if.timeout_err, u_if.phase_pulse};
    endfunction

    // Drive one cycle of inputs, record the expected result, step the clock.
    task automatic cyc(input logic st, ab, cd, md, sd,
                       input logic [2:0] ph, input logic pl);
        u_if.start     = st;
        u_if.abort     = ab;
        u_if.cfg_done  = cd;
        u_if.main_done = md;
        u_if.shut_done = sd;
        exp_q.push_back(mk(ph, pl));
        @(posedge CLK);
        #1;
        act_q.push_back(sample());
    endtask

    task automatic hard_reset();
        u_if.start = 0; u_if.abort = 0; u_if.cfg_done = 0;
        u_if.main_done = 0; u_if.shut_done = 0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        act_q.delete();
    endtask

    // start, four RESET cycles, then first CONFIG cycle.
    task automatic run_to_config();
        cyc(1, 0, 0, 0, 0, 3'd1, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 3'd1, 0);
        cyc(0, 0, 0, 0, 0, 3'd2, 1);
    endtask

    task automatic test_reset();
        logic [7:0] a;
        int i;
        u_if.start = 0; u_if.abort = 0; u_if.cfg_done = 0;
        u_if.main_done = 0; u_if.shut_done = 0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        a = sample();
        n_total++;
        if (a !== mk(3'd0, 0))
            $display("FAIL reset_state: got %b wanted %b", a, mk(3'd0, 0));
        else n_pass++;
        RST = 1'b0;
        exp_q.delete(); act_q.delete();
        // Only start leaves IDLE; the other inputs do nothing here.
        cyc(0, 1, 1, 1, 1, 3'd0, 0);
        cyc(0, 1, 0, 0, 0, 3'd0, 0);
        i = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = act_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL idle_ignore cyc%0d: got %b wanted %b", i, g, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_nominal();
        int i, pulses;
        hard_reset();
        run_to_config();
        repeat (2) cyc(0, 0, 0, 0, 0, 3'd2, 0);
        cyc(0, 0, 1, 0, 0, 3'd3, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 3'd3, 0);
        cyc(0, 0, 0, 1, 0, 3'd4, 1);
        cyc(0, 0, 0, 0, 0, 3'd4, 0);
        cyc(0, 0, 0, 0, 1, 3'd5, 1);
        cyc(0, 0, 1, 1, 1, 3'd5, 0);
        i = 0; pulses = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = act_q.pop_front();
            pulses += int'(g[0]);
            n_total++;
            if (g !== e) $display("FAIL nominal cyc%0d: got %b wanted %b", i, g, e);
            else n_pass++;
            i++;
        end
        n_total++;
        if (pulses !== 5) $display("FAIL nominal_pulse_count: got %0d wanted 5", pulses);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int i;
        hard_reset();
        run_to_config();
        cyc(0, 0, 1, 0, 0, 3'd3, 1);
        repeat (15) cyc(0, 0, 0, 0, 0, 3'd3, 0);
        cyc(0, 0, 0, 0, 0, 3'd7, 1);
        cyc(0, 0, 1, 1, 1, 3'd7, 0);
        cyc(1, 0, 0, 0, 0, 3'd1, 1);
        cyc(0, 0, 0, 0, 0, 3'd1, 0);
        i = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = act_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL timeout cyc%0d: got %b wanted %b", i, g, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_boundary();
        int i;
        // cfg_done in the 16th CONFIG cycle still wins over the timeout.
        hard_reset();
        run_to_config();
        repeat (15) cyc(0, 0, 0, 0, 0, 3'd2, 0);
        cyc(0, 0, 1, 0, 0, 3'd3, 1);
        // One cycle later is too late.
        hard_reset();
        run_to_config();
        repeat (15) cyc(0, 0, 0, 0, 0, 3'd2, 0);
        cyc(0, 0, 0, 0, 0, 3'd7, 1);
        cyc(0, 0, 1, 0, 0, 3'd7, 0);
        i = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = act_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL boundary cyc%0d: got %b wanted %b", i, g, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_abort();
        int i;
        hard_reset();
        run_to_config();
        cyc(0, 1, 1, 0, 0, 3'd4, 1);   // abort beats cfg_done
        cyc(0, 1, 0, 0, 0, 3'd4, 0);   // abort ignored in SHUTDOWN
        cyc(0, 0, 0, 0, 1, 3'd5, 1);
        cyc(1, 0, 0, 0, 0, 3'd1, 1);   // relaunch from DONE clears done
        // abort in RESET cycle 2 returns to IDLE with dut_rst held
        cyc(0, 0, 0, 0, 0, 3'd1, 0);
        cyc(0, 1, 0, 0, 0, 3'd0, 1);
        cyc(0, 0, 0, 0, 0, 3'd0, 0);
        // main_done together with abort
        run_to_config();
        cyc(0, 0, 1, 0, 0, 3'd3, 1);
        cyc(0, 1, 0, 1, 0, 3'd4, 1);
        i = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = act_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL abort cyc%0d: got %b wanted %b", i, g, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] a;
        int i;
        hard_reset();
        run_to_config();
        cyc(0, 0, 1, 0, 0, 3'd3, 1);
        cyc(1, 0, 0, 0, 0, 3'd3, 0);   // start while busy is ignored
        cyc(0, 0, 0, 0, 0, 3'd3, 0);
        i = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = act_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL async_pre cyc%0d: got %b wanted %b", i, g, e);
            else n_pass++;
            i++;
        end
        #2;
        RST = 1'b1;
        #1;
        a = sample();
        n_total++;
        if (a !== mk(3'd0, 0))
            $display("FAIL async_reset: got %b wanted %b", a, mk(3'd0, 0));
        else n_pass++;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_boundary();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
